// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch stage of a 5-stage MIPS pipeline, sitting directly in
// front of decode. It owns the fetch PC, issues word fetches to a
// variable-latency instruction memory (req/ready handshake, in-order rvalid),
// buffers returned instructions in a small FIFO and drives the IF/ID register.
// A hazard freeze holds IF/ID. A taken branch from EXE redirects the PC and
// squashes everything younger: buffered entries are flushed and responses
// still in flight are counted off and discarded as they arrive.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-low reset
//   freeze         in   hazard stall: hold IF/ID outputs, no FIFO pop
//   branch_taken   in   redirect request from EXE
//   branch_addr    in   redirect target (word-aligned byte address)
//   imem_req       out  fetch request valid
//   imem_addr      out  fetch address (current fetch PC)
//   imem_ready     in   memory accepts the request this cycle
//   imem_rvalid    in   response valid (in order, no back-pressure)
//   imem_rdata     in   fetched instruction word
//   if_pc          out  PC+4 of the delivered instruction
//   if_instruction out  delivered instruction, 32'b0 (NOP) on a bubble
//   if_valid       out  if_instruction holds a real instruction
// ----------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int DEPTH = 4,   // FIFO entries; also caps in-flight + buffered fetches
  parameter int AW    = 32   // PC / address width
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_addr,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic [AW-1:0] if_pc,
  output logic [31:0]   if_instruction,
  output logic          if_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  // pending can exceed DEPTH after back-to-back redirects (stale fetches are
  // still outstanding while new ones issue), so it gets extra headroom.
  localparam int CNT_W = PTR_W + 4;
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [OCC_W-1:0] count_q,    count_d;
  logic [CNT_W-1:0] pending_q,  pending_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]    if_pc_q,    if_pc_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic             if_valid_q, if_valid_d;

  logic [31:0]      fifo_instr_q [DEPTH];
  logic [AW-1:0]    fifo_pc_q    [DEPTH];

  // --------------------------------------------------------------------------
  // Request credit and response classification
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] live;          // accepted requests whose response will be kept
  logic [CNT_W-1:0] occ_plus_live;
  logic             issue;
  logic             rvalid_ok;     // response matching an outstanding request
  logic             drop_resp;
  logic             live_resp;
  logic [AW-1:0]    resp_addr;     // address of the request this response answers
  logic             push;
  logic             pop;

  assign live          = pending_q - drop_cnt_q;
  assign occ_plus_live = CNT_W'(count_q) + live;

  // Credit uses registered counts only: a pop in this cycle does not free a
  // slot for a request in this same cycle.
  assign imem_req  = !branch_taken && (occ_plus_live < CNT_W'(DEPTH)) &&
                     (pending_q != PEND_MAX);
  assign imem_addr = fetch_pc_q;
  assign issue     = imem_req && imem_ready;

  // An rvalid with nothing outstanding is a protocol error and is ignored.
  assign rvalid_ok = imem_rvalid && (pending_q != '0);
  assign drop_resp = rvalid_ok && (drop_cnt_q != '0);
  assign live_resp = rvalid_ok && (drop_cnt_q == '0);

  // Live requests cover a contiguous run of words ending just below fetch_pc,
  // so the oldest one (the one answering now) sits live words back.
  assign resp_addr = fetch_pc_q - (AW'(live) << 2);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: every signal gets its default before any branch so that no path
  // leaves a value unassigned, which would infer a latch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pending_d  = pending_q;
    drop_cnt_d = drop_cnt_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (branch_taken) begin
      // Redirect beats freeze. Every outstanding fetch is now stale, including
      // one answering this very cycle, which is simply not enqueued.
      fetch_pc_d = branch_addr;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pending_d  = pending_q - CNT_W'(rvalid_ok);
      drop_cnt_d = pending_q - CNT_W'(rvalid_ok);
      if_valid_d = 1'b0;
      if_instr_d = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + AW'(4);
      end
      pending_d = pending_q + CNT_W'(issue) - CNT_W'(rvalid_ok);
      if (drop_resp) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end

      if (freeze) begin
        // IF/ID held; responses still land in the FIFO.
        push = live_resp;
      end else if (count_q != '0) begin
        pop        = 1'b1;
        push       = live_resp;
        if_valid_d = 1'b1;
        if_instr_d = fifo_instr_q[rd_ptr_q];
        if_pc_d    = fifo_pc_q[rd_ptr_q];
      end else if (live_resp) begin
        // Empty FIFO: forward the response straight into IF/ID.
        if_valid_d = 1'b1;
        if_instr_d = imem_rdata;
        if_pc_d    = resp_addr + AW'(4);
      end else begin
        if_valid_d = 1'b0;
        if_instr_d = '0;
      end

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // --------------------------------------------------------------------------
  // Control and output registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      drop_cnt_q <= '0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      drop_cnt_q <= drop_cnt_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  // NOTE: FIFO storage has no reset; count_q alone says which entries are
  // meaningful, so clearing the array would only cost reset routing.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= resp_addr + AW'(4);
    end
  end

  assign if_pc          = if_pc_q;
  assign if_instruction = if_instr_q;
  assign if_valid       = if_valid_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Drives if_fetch_queue against an in-order, variable-latency instruction
// memory model. The reference model tracks the program at the level of
// "fetched since last redirect" and "delivered since last redirect": the
// next delivered instruction is always the next word in program order, and a
// new fetch may be requested while fewer than DEPTH words are fetched but not
// yet delivered.
// ----------------------------------------------------------------------------
module tb_if_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze;
  logic          branch_taken;
  logic [AW-1:0] branch_addr;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic [AW-1:0] if_pc;
  logic [31:0]   if_instruction;
  logic          if_valid;

  if_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .if_valid       (if_valid)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc;
  int    last_due;
  int    lat_lo, lat_hi;

  // ---------------- reference model ----------------
  int          epoch;
  int          issued, received, delivered;   // all since the last redirect
  logic [31:0] next_fetch, next_deliver;
  logic        exp_valid;
  logic [31:0] exp_pc, exp_instr;
  logic        exp_req;
  logic [31:0] exp_addr;
  logic        seen_req;
  logic [31:0] seen_addr;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic model_reset();
    mq.delete();
    cyc          = 0;
    last_due     = 0;
    epoch        = 0;
    issued       = 0;
    received     = 0;
    delivered    = 0;
    next_fetch   = '0;
    next_deliver = '0;
    exp_valid    = 1'b0;
    exp_pc       = '0;
    exp_instr    = '0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
  endtask

  // One clock cycle: inputs are already driven by the caller. Records the
  // request seen before the edge, advances memory and model across the edge,
  // then drives the memory response for the following edge.
  task automatic tick();
    mreq_t r;
    logic  did_issue, got_resp;
    int    d;
    #1;
    exp_req   = !branch_taken && ((issued - delivered) < DEPTH);
    exp_addr  = next_fetch;
    seen_req  = imem_req;
    seen_addr = imem_addr;
    did_issue = imem_req && imem_ready;
    got_resp  = imem_rvalid;
    @(posedge clk);
    cyc++;
    r.epoch = -1;
    if (got_resp && mq.size() > 0) r = mq.pop_front();
    if (did_issue) begin
      d = cyc + $urandom_range(lat_hi, lat_lo);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr: seen_addr, epoch: epoch, due: d});
    end
    if (branch_taken) begin
      epoch++;
      issued       = 0;
      received     = 0;
      delivered    = 0;
      next_fetch   = branch_addr;
      next_deliver = branch_addr;
      exp_valid    = 1'b0;
      exp_instr    = '0;
    end else begin
      if (did_issue) begin
        issued++;
        next_fetch = next_fetch + 32'd4;
      end
      if (got_resp && r.epoch == epoch) received++;
      if (!freeze) begin
        if (received > delivered) begin
          exp_valid    = 1'b1;
          exp_pc       = next_deliver + 32'd4;
          exp_instr    = instr_of(next_deliver);
          next_deliver = next_deliver + 32'd4;
          delivered++;
        end else begin
          exp_valid = 1'b0;
          exp_instr = '0;
        end
      end
    end
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; imem_ready = 1'b1;
    lat_lo = 1; lat_hi = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({if_valid, if_pc, if_instruction} !== {1'b0, 32'h0, 32'h0})
      $display("FAIL reset_outputs got v=%0b pc=%h ins=%h want all zero", if_valid, if_pc, if_instruction);
    else n_pass++;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL reset_fetch got req=%0b addr=%h want req=1 addr=0", imem_req, imem_addr);
    else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_stream();
    imem_ready = 1'b1; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (seen_req !== exp_req || (exp_req && seen_addr !== exp_addr))
        $display("FAIL stream_req cyc=%0d got req=%0b addr=%h want req=%0b addr=%h", cyc, seen_req, seen_addr, exp_req, exp_addr);
      else n_pass++;
      n_checks++;
      if ({if_valid, if_pc, if_instruction} !== {exp_valid, exp_pc, exp_instr})
        $display("FAIL stream_out cyc=%0d got v=%0b pc=%h ins=%h want v=%0b pc=%h ins=%h", cyc, if_valid, if_pc, if_instruction, exp_valid, exp_pc, exp_instr);
      else n_pass++;
    end
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'd44)
      $display("FAIL stream_steady got v=%0b pc=%h want v=1 pc=0000002c", if_valid, if_pc);
    else n_pass++;
  endtask

  task automatic test_freeze();
    logic [31:0] held_pc, held_ins;
    held_pc  = if_pc;
    held_ins = if_instruction;
    freeze = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (seen_req !== exp_req || (exp_req && seen_addr !== exp_addr))
        $display("FAIL freeze_req cyc=%0d got req=%0b addr=%h want req=%0b addr=%h", cyc, seen_req, seen_addr, exp_req, exp_addr);
      else n_pass++;
      n_checks++;
      if ({if_valid, if_pc, if_instruction} !== {1'b1, held_pc, held_ins})
        $display("FAIL freeze_hold cyc=%0d got v=%0b pc=%h ins=%h want v=1 pc=%h ins=%h", cyc, if_valid, if_pc, if_instruction, held_pc, held_ins);
      else n_pass++;
    end
    #1;
    n_checks++;
    if (imem_req !== 1'b0)
      $display("FAIL freeze_credit got req=%0b want req=0 with queue full", imem_req);
    else n_pass++;
    freeze = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({if_valid, if_pc, if_instruction} !== {exp_valid, exp_pc, exp_instr})
        $display("FAIL freeze_release cyc=%0d got v=%0b pc=%h ins=%h want v=%0b pc=%h ins=%h", cyc, if_valid, if_pc, if_instruction, exp_valid, exp_pc, exp_instr);
      else n_pass++;
      n_checks++;
      if (i == 0 && if_pc !== held_pc + 32'd4)
        $display("FAIL freeze_continue got pc=%h want pc=%h", if_pc, held_pc + 32'd4);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    bit found;
    imem_ready = 1'b1; lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 6; i++) tick();
    branch_taken = 1'b1; branch_addr = 32'h100;
    tick();
    branch_taken = 1'b0;
    n_checks++;
    if ({if_valid, if_instruction} !== {1'b0, 32'h0} || if_pc !== exp_pc)
      $display("FAIL branch_bubble got v=%0b pc=%h ins=%h want v=0 pc=%h ins=0", if_valid, if_pc, if_instruction, exp_pc);
    else n_pass++;
    tick();
    n_checks++;
    if (seen_req !== 1'b1 || seen_addr !== 32'h100)
      $display("FAIL branch_target got req=%0b addr=%h want req=1 addr=00000100", seen_req, seen_addr);
    else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (if_valid === 1'b1) begin
        found = 1'b1;
        n_checks++;
        if (if_pc !== 32'h104 || if_instruction !== instr_of(32'h100))
          $display("FAIL branch_first got pc=%h ins=%h want pc=00000104 ins=%h", if_pc, if_instruction, instr_of(32'h100));
        else n_pass++;
      end else begin
        n_checks++;
        if ({if_valid, if_instruction} !== {exp_valid, exp_instr})
          $display("FAIL branch_drop got v=%0b ins=%h want v=%0b ins=%h", if_valid, if_instruction, exp_valid, exp_instr);
        else n_pass++;
        tick();
      end
    end
    if (!found) begin
      n_checks++;
      $display("FAIL branch_timeout got no valid delivery within 10 cycles want pc=00000104");
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if ({if_valid, if_pc, if_instruction} !== {exp_valid, exp_pc, exp_instr})
        $display("FAIL branch_stream cyc=%0d got v=%0b pc=%h ins=%h want v=%0b pc=%h ins=%h", cyc, if_valid, if_pc, if_instruction, exp_valid, exp_pc, exp_instr);
      else n_pass++;
    end
  endtask

  task automatic test_branch_freeze();
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 4; i++) tick();
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h2000;
    tick();
    branch_taken = 1'b0;
    n_checks++;
    if ({if_valid, if_instruction} !== {1'b0, 32'h0})
      $display("FAIL brfrz_bubble got v=%0b ins=%h want v=0 ins=0", if_valid, if_instruction);
    else n_pass++;
    tick();
    n_checks++;
    if (seen_req !== 1'b1 || seen_addr !== 32'h2000)
      $display("FAIL brfrz_target got req=%0b addr=%h want req=1 addr=00002000", seen_req, seen_addr);
    else n_pass++;
    n_checks++;
    if ({if_valid, if_instruction} !== {1'b0, 32'h0})
      $display("FAIL brfrz_hold got v=%0b ins=%h want v=0 ins=0", if_valid, if_instruction);
    else n_pass++;
    freeze = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if ({if_valid, if_pc, if_instruction} !== {exp_valid, exp_pc, exp_instr})
        $display("FAIL brfrz_stream cyc=%0d got v=%0b pc=%h ins=%h want v=%0b pc=%h ins=%h", cyc, if_valid, if_pc, if_instruction, exp_valid, exp_pc, exp_instr);
      else n_pass++;
    end
  endtask

  task automatic test_ready_stall();
    logic [31:0] stall_addr;
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 3; i++) tick();
    stall_addr = next_fetch;
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (seen_req !== 1'b1 || seen_addr !== stall_addr)
        $display("FAIL stall_hold cyc=%0d got req=%0b addr=%h want req=1 addr=%h", cyc, seen_req, seen_addr, stall_addr);
      else n_pass++;
    end
    imem_ready = 1'b1;
    tick();
    n_checks++;
    if (seen_req !== 1'b1 || seen_addr !== stall_addr)
      $display("FAIL stall_accept got req=%0b addr=%h want req=1 addr=%h", seen_req, seen_addr, stall_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (seen_addr !== stall_addr + 32'd4)
      $display("FAIL stall_single got addr=%h want addr=%h", seen_addr, stall_addr + 32'd4);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({if_valid, if_pc, if_instruction} !== {exp_valid, exp_pc, exp_instr})
        $display("FAIL stall_stream cyc=%0d got v=%0b pc=%h ins=%h want v=%0b pc=%h ins=%h", cyc, if_valid, if_pc, if_instruction, exp_valid, exp_pc, exp_instr);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    lat_lo = 1; lat_hi = 2;
    for (int i = 0; i < 6; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({if_valid, if_pc, if_instruction} !== {1'b0, 32'h0, 32'h0})
      $display("FAIL async_reset got v=%0b pc=%h ins=%h want all zero before edge", if_valid, if_pc, if_instruction);
    else n_pass++;
    model_reset();
    #12;
    rst = 1'b1;
    tick();
    n_checks++;
    if (seen_req !== 1'b1 || seen_addr !== 32'h0)
      $display("FAIL async_restart got req=%0b addr=%h want req=1 addr=0", seen_req, seen_addr);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if ({if_valid, if_pc, if_instruction} !== {exp_valid, exp_pc, exp_instr})
        $display("FAIL async_stream cyc=%0d got v=%0b pc=%h ins=%h want v=%0b pc=%h ins=%h", cyc, if_valid, if_pc, if_instruction, exp_valid, exp_pc, exp_instr);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      freeze       = ($urandom_range(9, 0) < 3);
      imem_ready   = ($urandom_range(9, 0) < 7);
      branch_taken = ($urandom_range(39, 0) == 0);
      // Some redirects land just below the top of the address space so the
      // PC+4 and fetch increments wrap.
      branch_addr  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | {28'h0, 2'(($urandom & 3)), 2'b00})
                                                  : {($urandom & 32'h0000_FFFF), 2'b00};
      tick();
      n_checks++;
      if (seen_req !== exp_req || (exp_req && seen_addr !== exp_addr))
        $display("FAIL random_req cyc=%0d got req=%0b addr=%h want req=%0b addr=%h", cyc, seen_req, seen_addr, exp_req, exp_addr);
      else n_pass++;
      n_checks++;
      if ({if_valid, if_pc, if_instruction} !== {exp_valid, exp_pc, exp_instr})
        $display("FAIL random_out cyc=%0d got v=%0b pc=%h ins=%h want v=%0b pc=%h ins=%h", cyc, if_valid, if_pc, if_instruction, exp_valid, exp_pc, exp_instr);
      else n_pass++;
    end
    freeze = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got simulation still running want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_freeze();
    test_branch();
    test_branch_freeze();
    test_ready_stall();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
